// File: rtl/epb_slave_pkg.sv
// rtl/epb_slave_pkg.sv - shared types and constants for the EPB slave path
package epb_slave_pkg;

    localparam int EPB_BUS_AW = 29;
    localparam int EPB_DW     = 16;

    localparam logic [EPB_DW-1:0] EPB_TIMEOUT_RDATA = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RDY,
        ST_WAIT_CS
    } epb_state_e;

endpackage

// File: rtl/epb_slave_if.sv
// rtl/epb_slave_if.sv - EPB pad-side strobes plus internal register bus signals
interface epb_slave_if;
    import epb_slave_pkg::*;

    logic                  epb_cs_n;
    logic                  epb_oe_n;
    logic                  epb_r_w_n;
    logic [1:0]            epb_be_n;
    logic [22:0]           epb_addr;
    logic [5:0]            epb_addr_gp;
    logic [EPB_DW-1:0]     epb_data_in;
    logic [EPB_DW-1:0]     epb_data_out;
    logic                  epb_data_oe_n;
    logic                  epb_rdy;
    logic                  epb_rdy_oe;

    logic                  bus_req;
    logic                  bus_rnw;
    logic [EPB_BUS_AW-1:0] bus_addr;
    logic [1:0]            bus_be;
    logic [EPB_DW-1:0]     bus_wdata;
    logic [EPB_DW-1:0]     bus_rdata;
    logic                  bus_ack;
    logic                  timeout_err;

    modport slave (
        input  epb_cs_n, epb_oe_n, epb_r_w_n, epb_be_n, epb_addr, epb_addr_gp, epb_data_in,
        output epb_data_out, epb_data_oe_n, epb_rdy, epb_rdy_oe,
        output bus_req, bus_rnw, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack,
        output timeout_err
    );

    modport master (
        output epb_cs_n, epb_oe_n, epb_r_w_n, epb_be_n, epb_addr, epb_addr_gp, epb_data_in,
        input  epb_data_out, epb_data_oe_n, epb_rdy, epb_rdy_oe,
        input  bus_req, bus_rnw, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack,
        input  timeout_err
    );

endinterface

// File: rtl/epb_slave_timeout.sv
// rtl/epb_slave_timeout.sv - REQ-phase cycle counter with terminal-count flag
module epb_slave_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tc
);

    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;

    // Held at zero outside REQ, so every REQ entry starts counting from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!run) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign tc = run && (cnt_q == LAST);

endmodule

// File: rtl/epb_slave_ctrl.sv
// rtl/epb_slave_ctrl.sv - EPB chip-select cycle to register-bus transfer (optional EPB_SLAVE_TIMEOUT_EN)
module epb_slave_ctrl
    import epb_slave_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        epb_clk,
    input  logic        epb_rst,
    epb_slave_if.slave  epb
);

    epb_state_e            state_q, state_d;
    logic                  cs_q, armed_q, abort_q;
    logic                  start, acked, expired;
    logic                  rnw_q, data_oe_n_q;
    logic [EPB_BUS_AW-1:0] addr_q;
    logic [1:0]            be_q;
    logic [EPB_DW-1:0]     wdata_q, rdata_q;

    // armed_q blocks a cs_n that was already low across reset release.
    assign start = (state_q == ST_IDLE) && armed_q && cs_q && !epb.epb_cs_n;
    assign acked = (state_q == ST_REQ) && epb.bus_ack;

`ifdef EPB_SLAVE_TIMEOUT_EN
    logic tc, terr_q;

    epb_slave_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk (epb_clk),
        .rst (epb_rst),
        .run (state_q == ST_REQ),
        .tc  (tc)
    );

    assign expired = tc && !epb.bus_ack;

    always_ff @(posedge epb_clk or posedge epb_rst) begin
        if (epb_rst) terr_q <= 1'b0;
        else         terr_q <= expired;
    end

    assign epb.timeout_err = terr_q;
`else
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_unused
    end

    assign expired         = 1'b0;
    assign epb.timeout_err = 1'b0;
`endif

    always_ff @(posedge epb_clk or posedge epb_rst) begin
        if (epb_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // A master abort (cs_n high at any point in REQ) skips the ready strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_REQ;
            ST_REQ:     if (acked || expired)
                            state_d = (abort_q || epb.epb_cs_n) ? ST_IDLE : ST_RDY;
            ST_RDY:     state_d = ST_WAIT_CS;
            ST_WAIT_CS: if (epb.epb_cs_n) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge epb_clk or posedge epb_rst) begin
        if (epb_rst) begin
            cs_q        <= 1'b1;
            armed_q     <= 1'b0;
            abort_q     <= 1'b0;
            rnw_q       <= 1'b1;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            data_oe_n_q <= 1'b1;
        end else begin
            cs_q    <= epb.epb_cs_n;
            armed_q <= armed_q | epb.epb_cs_n;
            abort_q <= (state_q == ST_REQ) && (abort_q || epb.epb_cs_n);
            if (start) begin
                rnw_q   <= epb.epb_r_w_n;
                addr_q  <= {epb.epb_addr_gp, epb.epb_addr};
                be_q    <= ~epb.epb_be_n;
                wdata_q <= epb.epb_data_in;
            end
            if (acked && rnw_q) begin
                rdata_q <= epb.bus_rdata;
            end else if (expired && rnw_q) begin
                rdata_q <= EPB_TIMEOUT_RDATA;
            end
            data_oe_n_q <= !(((state_q == ST_RDY) || (state_q == ST_WAIT_CS)) &&
                             rnw_q && !epb.epb_oe_n && !epb.epb_cs_n);
        end
    end

    assign epb.bus_req       = (state_q == ST_REQ);
    assign epb.bus_rnw       = rnw_q;
    assign epb.bus_addr      = addr_q;
    assign epb.bus_be        = be_q;
    assign epb.bus_wdata     = wdata_q;
    assign epb.epb_data_out  = rdata_q;
    assign epb.epb_data_oe_n = data_oe_n_q;
    assign epb.epb_rdy       = (state_q == ST_RDY);
    assign epb.epb_rdy_oe    = !epb_rst && (!epb.epb_cs_n || (state_q != ST_IDLE));

endmodule

// File: doc/epb_slave_ctrl.md
# epb_slave_ctrl

Transaction controller for the EPB slave path, directly downstream of the EPB pad/buffer stage. It consumes the buffered, de-tristated EPB strobes, address and write data, and converts each processor chip-select cycle into a single request/acknowledge transfer on the internal register bus. It returns read data, the data output-enable and the ready strobe with its output-enable to the buffer stage.

## Interface
- `TIMEOUT_CYCLES`, default 1024: number of cycles to wait for `bus_ack` before forcing completion. Only used with `EPB_SLAVE_TIMEOUT_EN`. Legal range is 2 to 65535.
- `epb_clk` in 1: the single clock. All logic is rising-edge.
- `epb_rst` in 1: reset, asynchronous and active-high.
- `epb_cs_n` in 1: chip select, active-low.
- `epb_oe_n` in 1: output enable, active-low.
- `epb_r_w_n` in 1: 1 = read, 0 = write.
- `epb_be_n` in 2: byte enables, active-low.
- `epb_addr` in 23: word address.
- `epb_addr_gp` in 6: general-purpose address bits.
- `epb_data_in` in 16: write data from the pads.
- `epb_data_out` out 16: registered read data to the pads.
- `epb_data_oe_n` out 1: pad data driver enable, active-low.
- `epb_rdy` out 1: transfer-complete strobe.
- `epb_rdy_oe` out 1: ready driver enable.
- `bus_req` out 1: internal bus request, held until acknowledged.
- `bus_rnw` out 1: 1 = read.
- `bus_addr` out 29: `{epb_addr_gp, epb_addr}`.
- `bus_be` out 2: byte enables, active-high (inverted `epb_be_n`).
- `bus_wdata` out 16: write data.
- `bus_rdata` in 16: read data. Valid in the `bus_ack` cycle.
- `bus_ack` in 1: single-cycle acknowledge.
- `timeout_err` out 1: one-cycle pulse when a transfer is forcibly completed.

## Operation
- States are IDLE, REQ, RDY and WAIT_CS.
- **IDLE.** `cs_q` is `epb_cs_n` registered once.
  - A falling edge (`cs_q` = 1, `epb_cs_n` = 0) latches `epb_addr`, `epb_addr_gp`, `epb_r_w_n`, `epb_be_n` and `epb_data_in` into the `bus_*` registers.
  - The state then moves to REQ.
  - `cs_n` held low through reset release does not start a transfer; only a true falling edge does.
- **REQ.** `bus_req` = 1.
  - On `bus_ack`: for a read, capture `bus_rdata` into `epb_data_out`. Drop `bus_req` and go to RDY.
- **RDY.** `epb_rdy` = 1 for exactly one cycle, then go to WAIT_CS.
- **WAIT_CS.** Stay until `epb_cs_n` = 1, then go to IDLE.
- `epb_rdy_oe` = 1 whenever `epb_cs_n` = 0 or the state is not IDLE. This keeps the ready line actively low until the strobe.
- `epb_data_oe_n` = 0 only when all of the following hold:
  - state is RDY or WAIT_CS;
  - `bus_rnw` = 1;
  - `epb_oe_n` = 0;
  - `epb_cs_n` = 0.
  
  It is registered, so it follows these conditions with one cycle of lag.
- **Master abort** (`epb_cs_n` rises while in REQ):
  - The internal transfer still completes; `bus_req` is held until `bus_ack`.
  - `epb_rdy` is suppressed.
  - The state goes directly to IDLE.
- `bus_*` address, control and write-data outputs are stable from the REQ entry cycle until the next falling edge.
- **Reset, including mid-transfer.** All of the following take effect immediately, with no completion of the pending bus transfer:
  - state = IDLE;
  - `bus_req`, `epb_rdy`, `epb_rdy_oe` and `timeout_err` = 0;
  - `epb_data_oe_n` = 1;
  - `epb_data_out`, `bus_addr`, `bus_be` and `bus_wdata` = 0;
  - `bus_rnw` = 1;
  - `cs_q` = 1.

## Timing
- `epb_cs_n` falls in the sample at cycle N; `bus_req` = 1 at cycle N+1.
- `bus_ack` arrives at cycle M (M ≥ N+1); `bus_req` = 0 and `epb_rdy` = 1 at cycle M+1; `epb_rdy` = 0 at M+2.
- Read data is valid on `epb_data_out` at M+1 and remains valid until the next read capture.
- `bus_ack` in the same cycle `bus_req` first asserts is legal. The minimum cycle is 3 clocks from the falling edge to `epb_rdy`.
- `bus_ack` outside REQ is ignored.

## Configuration
- **`EPB_SLAVE_TIMEOUT_EN` defined:**
  - A counter clears on REQ entry and increments each REQ cycle.
  - When it reaches `TIMEOUT_CYCLES - 1` without `bus_ack`:
    - `bus_req` drops;
    - a read returns `16'hDEAD`;
    - `timeout_err` pulses for one cycle, coincident with entry to RDY;
    - the transfer then completes as normal.
  - A `bus_ack` in the terminal cycle wins: real data is returned and there is no error.
- **Undefined:** REQ waits indefinitely, `timeout_err` is tied 0, and no counter logic is present.

## Structure
- Package `epb_slave_pkg` holds:
  - the state enum;
  - `EPB_TIMEOUT_RDATA = 16'hDEAD`;
  - `EPB_BUS_AW = 29`;
  - `EPB_DW = 16`.
- One sub-module, `epb_slave_timeout`, contains the counter plus the terminal-count flag. It is instantiated only under `EPB_SLAVE_TIMEOUT_EN`.

## Test plan
- **Write:** cs_n falls with addr 23'h000123, gp 6'h01, r_w_n 0, be_n 2'b00, data 16'hBEEF; ack 2 cycles later.
  - Expect `bus_addr` = 29'h00800123, `bus_be` = 2'b11, `bus_wdata` = 16'hBEEF.
  - Expect a single `epb_rdy` pulse, and `epb_data_oe_n` to stay at 1.
- **Read:** ack in the same cycle as `bus_req` with `bus_rdata` 16'h1234.
  - Expect `epb_rdy` 3 cycles after the falling edge.
  - Expect `epb_data_out` = 16'h1234 and `epb_data_oe_n` = 0 while oe_n and cs_n are low.
- **Master abort:** cs_n rises during REQ, ack 5 cycles later.
  - Expect `bus_req` held until the ack and no `epb_rdy`.
  - Expect the state back in IDLE and a new falling edge accepted.
- **Timeout** (macro on, `TIMEOUT_CYCLES` 8): read with no ack.
  - Expect `bus_req` high for 8 cycles.
  - Expect `epb_rdy` and `timeout_err` to pulse, and `epb_data_out` = 16'hDEAD.
  - Repeat with the ack in the terminal cycle: expect real data and no error.
- **Reset in REQ:** assert `epb_rst` asynchronously.
  - Expect all outputs at their reset values within the same cycle.
  - With cs_n still low after release, expect no new request until cs_n toggles high then low.
